// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: round-robin poller that shares one UART link among up
// to five remote sensors. Each transaction sends a one-byte request, collects a
// data byte and a CRC byte, has an external checker judge them, and stores the
// outcome in a bus-readable RESULT register.
// Build option: define SCHED_RETRY_EN to retry a failed attempt up to
// MAX_RETRIES times before giving up on that sensor. Without it, any failure
// marks the sensor in error and the scheduler moves on.
module sensor_poll_scheduler #(
    parameter int NUM_SENSORS   = 5,
    parameter int TIMEOUT_TICKS = 31,
    parameter int MAX_RETRIES   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        chip_select,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  uart_din,
    output logic        uart_wr_en,
    input  logic        uart_tx_busy,
    input  logic [7:0]  uart_dout,
    input  logic        uart_rdy,
    output logic        uart_rdy_clr,
    input  logic        uart_rxclk_en,
    output logic [7:0]  crc_data,
    output logic [7:0]  crc_code,
    input  logic        crc_ok,
    input  logic        crc_alarm,
    output logic        alarm_irq,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_WAIT_CRC  = 3'd3,
        S_CHECK     = 3'd4,
        S_RECOVERY  = 3'd5
    } state_t;

    localparam int         TW   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [4:0] IMPL = 5'((1 << NUM_SENSORS) - 1);

    state_t state_q, state_d;
    logic        run_q, run_d;
    logic [4:0]  mask_q, mask_d;
    logic        alarm_q, alarm_d;
    logic [15:0] errcnt_q, errcnt_d;
    logic [2:0]  cur_q, cur_d;
    logic [2:0]  last_q, last_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]  crc_data_q, crc_data_d;
    logic [7:0]  crc_code_q, crc_code_d;
    logic [NUM_SENSORS-1:0][25:0] res_q, res_d;
    logic [31:0] readdata_q, readdata_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  din_q, din_d;
    logic        rdy_clr_q, rdy_clr_d;
`ifdef SCHED_RETRY_EN
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    logic [RW-1:0] retry_q, retry_d;
`endif

    logic        bus_rd, bus_wr;
    logic        rdy_seen, fail;
    logic [4:0]  en_mask;
    logic [2:0]  pick;
    logic        pick_vld;
    logic [3:0]  cand;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign bus_rd   = chip_select & read;
    assign bus_wr   = chip_select & write;
    assign en_mask  = mask_q & IMPL;
    // A byte still flagged ready while our clear pulse is in flight is the one
    // already captured, so it must not be taken a second time.
    assign rdy_seen = uart_rdy & ~rdy_clr_q;
    assign unused_wdata = &{1'b0, writedata[31:17], writedata[15:13], writedata[7:1]};

    // Round-robin pick: first enabled sensor after the last serviced one, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_SENSORS; k++) begin
            cand = {1'b0, last_q} + 4'(k);
            if (cand > 4'(NUM_SENSORS)) cand = cand - 4'(NUM_SENSORS);
            if (!pick_vld && en_mask[3'(cand - 4'd1)]) begin
                pick     = 3'(cand);
                pick_vld = 1'b1;
            end
        end
    end

    // Register read multiplexer; unimplemented RESULT slots read as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: rd_mux = {19'd0, mask_q, 7'd0, run_q};
            3'd1: rd_mux = {15'd0, alarm_q, 5'd0, cur_q, 5'd0, state_q};
            3'd2: rd_mux = {16'd0, errcnt_q};
            default: begin
                for (int i = 0; i < NUM_SENSORS; i++)
                    if (address == 3'(i + 3)) rd_mux = {6'd0, res_q[i]};
            end
        endcase
    end

    // Bus side effects, then the transaction FSM and its failure handling.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        mask_d     = mask_q;
        alarm_d    = alarm_q;
        errcnt_d   = errcnt_q;
        cur_d      = cur_q;
        last_d     = last_q;
        tmo_d      = tmo_q;
        crc_data_d = crc_data_q;
        crc_code_d = crc_code_q;
        res_d      = res_q;
        readdata_d = readdata_q;
        din_d      = din_q;
        wr_en_d    = 1'b0;
        rdy_clr_d  = 1'b0;
        fail       = 1'b0;
`ifdef SCHED_RETRY_EN
        retry_d    = retry_q;
`endif

        if (bus_rd) readdata_d = rd_mux;
        if (bus_wr) begin
            case (address)
                3'd0: begin
                    run_d  = writedata[0];
                    mask_d = writedata[12:8];
                end
                3'd1: if (writedata[16]) alarm_d = 1'b0;
                3'd2: errcnt_d = '0;
                default: ;
            endcase
        end
        // Reading a RESULT consumes its valid flag; a same-cycle update below wins.
        for (int i = 0; i < NUM_SENSORS; i++)
            if (bus_rd && address == 3'(i + 3)) res_d[i][24] = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_q && pick_vld) begin
                    cur_d   = pick;
                    last_d  = pick;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!uart_tx_busy) begin
                    wr_en_d = 1'b1;
                    din_d   = {5'd0, cur_q};
                    tmo_d   = '0;
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA, S_WAIT_CRC: begin
                if (rdy_seen) begin
                    if (state_q == S_WAIT_DATA) begin
                        crc_data_d = uart_dout;
                        state_d    = S_WAIT_CRC;
                    end else begin
                        crc_code_d = uart_dout;
                        state_d    = S_CHECK;
                    end
                    rdy_clr_d = 1'b1;
                    tmo_d     = '0;
                end else if (uart_rxclk_en) begin
                    if (tmo_q == TW'(TIMEOUT_TICKS - 1)) fail = 1'b1;
                    else                                 tmo_d = tmo_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (crc_alarm) begin
                    state_d = S_RECOVERY;
                end else if (crc_ok) begin
                    for (int i = 0; i < NUM_SENSORS; i++)
                        if (cur_q == 3'(i + 1))
                            res_d[i] = {1'b0, 1'b1, 5'd0, cur_q, crc_code_q, crc_data_q};
`ifdef SCHED_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = S_IDLE;
                end else begin
                    fail = 1'b1;
                end
            end
            S_RECOVERY: begin
                alarm_d = 1'b1;
                last_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            // A clearing write in the same cycle takes precedence over the count.
            if (!(bus_wr && address == 3'd2) && errcnt_q != 16'hFFFF)
                errcnt_d = errcnt_q + 16'd1;
`ifdef SCHED_RETRY_EN
            if (retry_q < RW'(MAX_RETRIES)) begin
                retry_d = retry_q + 1'b1;
                state_d = S_SEND;
            end else begin
                for (int i = 0; i < NUM_SENSORS; i++)
                    if (cur_q == 3'(i + 1)) begin
                        res_d[i][25]    = 1'b1;
                        res_d[i][23:16] = {5'd0, cur_q};
                    end
                retry_d = '0;
                state_d = S_IDLE;
            end
`else
            for (int i = 0; i < NUM_SENSORS; i++)
                if (cur_q == 3'(i + 1)) begin
                    res_d[i][25]    = 1'b1;
                    res_d[i][23:16] = {5'd0, cur_q};
                end
            state_d = S_IDLE;
`endif
        end
    end

    // State and register file; synchronous reset clears everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            run_q      <= 1'b0;
            mask_q     <= '0;
            alarm_q    <= 1'b0;
            errcnt_q   <= '0;
            cur_q      <= '0;
            last_q     <= '0;
            tmo_q      <= '0;
            crc_data_q <= '0;
            crc_code_q <= '0;
            res_q      <= '0;
            readdata_q <= '0;
            wr_en_q    <= 1'b0;
            din_q      <= '0;
            rdy_clr_q  <= 1'b0;
`ifdef SCHED_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            mask_q     <= mask_d;
            alarm_q    <= alarm_d;
            errcnt_q   <= errcnt_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            tmo_q      <= tmo_d;
            crc_data_q <= crc_data_d;
            crc_code_q <= crc_code_d;
            res_q      <= res_d;
            readdata_q <= readdata_d;
            wr_en_q    <= wr_en_d;
            din_q      <= din_d;
            rdy_clr_q  <= rdy_clr_d;
`ifdef SCHED_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign readdata     = readdata_q;
    assign uart_din     = din_q;
    assign uart_wr_en   = wr_en_q;
    assign uart_rdy_clr = rdy_clr_q;
    assign crc_data     = crc_data_q;
    assign crc_code     = crc_code_q;
    assign alarm_irq    = alarm_q;
    assign state        = state_q;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler. The bench plays the UART (request
// capture, byte delivery with ready/clear handshake, rx ticks) and the CRC
// checker (good CRC means crc == data ^ 8'h5A). Expected values are hand-derived.
module tb_sensor_poll_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        chip_select = 1'b0, read = 1'b0, write = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  uart_din;
    logic        uart_wr_en;
    logic        uart_tx_busy = 1'b1;
    logic [7:0]  uart_dout = '0;
    logic        uart_rdy = 1'b0;
    logic        uart_rdy_clr;
    logic        uart_rxclk_en = 1'b0;
    logic [7:0]  crc_data, crc_code;
    logic        crc_ok, crc_alarm;
    logic        alarm_irq;
    logic [2:0]  state;
    logic        alarm_force = 1'b0;

`ifdef SCHED_RETRY_EN
    localparam int NATT = 3;
`else
    localparam int NATT = 1;
`endif

    int n_vec = 0;
    int n_bad = 0;

    assign crc_ok    = (crc_code == (crc_data ^ 8'h5A));
    assign crc_alarm = alarm_force;

    sensor_poll_scheduler dut (
        .clock(clock), .reset(reset),
        .chip_select(chip_select), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .uart_din(uart_din), .uart_wr_en(uart_wr_en), .uart_tx_busy(uart_tx_busy),
        .uart_dout(uart_dout), .uart_rdy(uart_rdy), .uart_rdy_clr(uart_rdy_clr),
        .uart_rxclk_en(uart_rxclk_en),
        .crc_data(crc_data), .crc_code(crc_code), .crc_ok(crc_ok), .crc_alarm(crc_alarm),
        .alarm_irq(alarm_irq), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        chip_select = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clock);
        chip_select = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clock);
        chip_select = 1'b1; read = 1'b1; address = a;
        @(negedge clock);
        chip_select = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // Release the transmitter, catch the request byte, then hold the link busy
    // so the scheduler parks in SEND until the bench asks for the next request.
    task automatic wait_req(output logic [7:0] id);
        bit got = 0;
        uart_tx_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (uart_wr_en) begin got = 1; break; end
        end
        id = uart_din;
        uart_tx_busy = 1'b1;
        if (!got) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [2:0] st);
        bit got = 0;
        @(negedge clock);
        uart_dout = b; uart_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (uart_rdy_clr) begin got = 1; break; end
        end
        st = state;
        if (!got) chk("rdy_clr_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1 uart_rdy = 1'b0;
    endtask

    task automatic reply(input logic [7:0] d, input logic [7:0] c);
        logic [2:0] st;
        send_byte(d, st);
        send_byte(c, st);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            uart_rxclk_en = 1'b1;
        end
        @(negedge clock);
        uart_rxclk_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; uart_rdy = 1'b0; uart_rxclk_en = 1'b0;
        alarm_force = 1'b0; uart_tx_busy = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  id;
        logic [2:0]  st;
        int          cnt;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_state", state, 0);
        chk("rst_wr_en", uart_wr_en, 0);
        chk("rst_rdy_clr", uart_rdy_clr, 0);
        chk("rst_din", uart_din, 0);
        chk("rst_crc", {crc_data, crc_code}, 0);
        chk("rst_irq", alarm_irq, 0);
        chk("rst_readdata", readdata, 0);
        reset = 1'b0;
        bus_read(3'd1, d); chk("rst_status", d, 0);
        bus_read(3'd2, d); chk("rst_errcnt", d, 0);

        // Sensors 1-2, good replies, state walk
        bus_write(3'd0, 32'h0000_0301);
        bus_read(3'd0, d); chk("ctrl_rb", d, 32'h0000_0301);
        chk("st_send", state, 1);
        repeat (3) @(negedge clock);
        chk("st_send_busy", state, 1);
        chk("wr_en_busy", uart_wr_en, 0);
        wait_req(id); chk("req1_id", id, 1);
        chk("st_wait_data", state, 2);
        send_byte(8'hA5, st); chk("st_wait_crc", st, 3);
        send_byte(8'hFF, st); chk("st_check", st, 4);
        chk("crc_bytes", {crc_data, crc_code}, 32'h0000_A5FF);
        bus_read(3'd3, d); chk("result1", d, 32'h0101_FFA5);
        bus_read(3'd3, d); chk("result1_rdclr", d, 32'h0001_FFA5);
        wait_req(id); chk("req2_id", id, 2);
        reply(8'h3C, 8'h66);
        bus_read(3'd4, d); chk("result2", d, 32'h0102_663C);

        // Bad CRC, then a good reply
        wait_req(id); chk("req3_id", id, 1);
        reply(8'h11, 8'h00);
        wait_req(id);
`ifdef SCHED_RETRY_EN
        chk("req_after_bad", id, 1);
`else
        chk("req_after_bad", id, 2);
`endif
        reply(8'h22, 8'h78);
        bus_read(3'd2, d); chk("errcnt_badcrc", d, 1);
`ifdef SCHED_RETRY_EN
        bus_read(3'd3, d); chk("result1_retry_ok", d, 32'h0101_7822);
`else
        bus_read(3'd3, d); chk("result1_err", d, 32'h0201_FFA5);
        bus_read(3'd4, d); chk("result2_ok", d, 32'h0102_7822);
`endif

        // Silent sensor 3: timeout after exactly 31 ticks per attempt
        do_reset();
        bus_write(3'd0, 32'h0000_0401);
        for (int a = 0; a < NATT; a++) begin
            wait_req(id); chk("to_id", id, 3);
            tick(30);
            bus_read(3'd2, d); chk("to_errcnt_pre", d, a);
            chk("to_state", state, 2);
            tick(1);
            bus_read(3'd2, d); chk("to_errcnt", d, a + 1);
        end
        bus_read(3'd5, d); chk("result3_err", d, 32'h0203_0000);
        bus_write(3'd2, 32'h0);
        bus_read(3'd2, d); chk("errcnt_clr", d, 0);

        // CRC alarm on sensor 4
        do_reset();
        bus_write(3'd0, 32'h0000_0901);
        wait_req(id); chk("al_req1", id, 1);
        reply(8'h10, 8'h4A);
        wait_req(id); chk("al_req4", id, 4);
        send_byte(8'h44, st);
        alarm_force = 1'b1;
        send_byte(8'h1E, st);
        alarm_force = 1'b0;
        repeat (4) @(negedge clock);
        chk("alarm_irq", alarm_irq, 1);
        bus_read(3'd1, d); chk("status_alarm", d, 32'h0001_0101);
        bus_read(3'd6, d); chk("result4_untouched", d, 0);
        bus_read(3'd2, d); chk("alarm_errcnt", d, 0);
        wait_req(id); chk("rr_after_alarm", id, 1);
        bus_write(3'd1, 32'h0001_0000);
        chk("irq_cleared", alarm_irq, 0);

        // Reset during WAIT_CRC
        do_reset();
        bus_write(3'd0, 32'h0000_0601);
        wait_req(id); chk("rs_req", id, 2);
        send_byte(8'h55, st); chk("rs_wait_crc", st, 3);
        bus_read(3'd1, d); chk("status_wait_crc", d, 32'h0000_0203);
        reset = 1'b1;
        @(negedge clock);
        chk("rst2_state", state, 0);
        chk("rst2_readdata", readdata, 0);
        chk("rst2_din", uart_din, 0);
        chk("rst2_crc_data", crc_data, 0);
        chk("rst2_outs", {uart_wr_en, uart_rdy_clr, alarm_irq}, 0);
        reset = 1'b0;
        bus_write(3'd0, 32'h0000_0601);
        wait_req(id); chk("req_after_reset", id, 2);

        // Clear run mid-WAIT_DATA: transaction completes, then IDLE holds
        bus_write(3'd0, 32'h0000_0600);
        reply(8'h77, 8'h2D);
        uart_tx_busy = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clock);
            if (uart_wr_en) cnt++;
        end
        chk("no_wr_after_stop", cnt, 0);
        chk("idle_hold", state, 0);
        bus_read(3'd4, d); chk("result2_stop", d, 32'h0102_2D77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
